// File: rtl/vga_fb_pkg.sv
// Shared constants, clear-engine state type and cell address helper for the
// 160x120 framebuffer behind the 640x480 VGA scanout.
package vga_fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = 19200;
  localparam int H_VIS    = 640;
  localparam int V_VIS    = 480;
  localparam int ADDR_W   = 15;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CLEAR
  } clr_state_e;

  // y*160 + x built from shifts; y<=119, x<=159 keeps the sum below 19200.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] y, input logic [7:0] x);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_fb_clear.sv
// Clear engine: accepts a fill command, optionally waits for vertical blank,
// then sweeps every framebuffer cell with the latched colour on free cycles.
module vga_fb_clear
  import vga_fb_pkg::*;
#(
  parameter bit CLR_IN_VBLANK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot_free,
  input  logic              clr_start,
  input  logic [2:0]        clr_color,
  input  logic              vblank_start,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        data,
  output logic              busy
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        color_q, color_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    color_d = color_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          color_d = clr_color;
          addr_d  = '0;
          state_d = CLR_IN_VBLANK ? ARM : CLEAR;
        end
      end
      ARM: begin
        if (vblank_start) state_d = CLEAR;
      end
      CLEAR: begin
        // The counter only moves on cycles the scanout leaves free.
        if (slot_free) begin
          if (addr_q == ADDR_W'(FB_DEPTH - 1)) state_d = IDLE;
          else                                 addr_d  = addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    color_q <= color_d;
  end

  assign req  = (state_q == CLEAR);
  assign addr = addr_q;
  assign data = color_q;
  assign busy = (state_q != IDLE);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer controller: scanout fetch decode, fixed-priority RAM sharing
// (scanout > clear > writer) and the 2-cycle colour/sync output pipeline.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter bit CLR_IN_VBLANK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic              hsync,
  output logic              vsync,
  output logic              r,
  output logic              g,
  output logic              b,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  output logic              wr_ack,
  input  logic              clr_start,
  input  logic [2:0]        clr_color,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata
);

  logic              visible_p0;
  logic              fetch_p0;
  logic [ADDR_W-1:0] fetch_addr_p0;
  logic              vblank_start;
  logic              clr_req;
  logic [ADDR_W-1:0] clr_addr;
  logic [2:0]        clr_data;

  // Stage p0: decode the timing counters
  assign visible_p0    = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));
  assign fetch_p0      = visible_p0 && (hcnt[1:0] == 2'b00);
  assign fetch_addr_p0 = cell_addr(vcnt[8:2], hcnt[9:2]);
  assign vblank_start  = (vcnt == 10'(V_VIS)) && (hcnt == 10'd0);

  vga_fb_clear #(
    .CLR_IN_VBLANK(CLR_IN_VBLANK)
  ) u_clear (
    .clk         (clk),
    .rst         (rst),
    .slot_free   (~fetch_p0),
    .clr_start   (clr_start),
    .clr_color   (clr_color),
    .vblank_start(vblank_start),
    .req         (clr_req),
    .addr        (clr_addr),
    .data        (clr_data),
    .busy        (clr_busy)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (!rst) begin
      if (fetch_p0) begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr_p0;
      end else if (clr_req) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = clr_data;
      end else if (wr_req) begin
        // Out-of-range writes are acknowledged but never reach the RAM.
        wr_ack = 1'b1;
        if (wr_addr < ADDR_W'(FB_DEPTH)) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
      end
    end
  end

  logic       vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic       fetch_p1_d, fetch_p1_q;
  logic       hsync_p1_d, hsync_p1_q, hsync_p2_d, hsync_p2_q;
  logic       vsync_p1_d, vsync_p1_q, vsync_p2_d, vsync_p2_q;
  logic [2:0] pixel_p2_d, pixel_p2_q;

  // Stage p1: read in flight; stage p2: pixel captured, held for the cell's 4 columns
  always_comb begin
    vld_p1_d   = visible_p0;
    vld_p2_d   = vld_p1_q;
    fetch_p1_d = fetch_p0;
    hsync_p1_d = hsync_i;
    hsync_p2_d = hsync_p1_q;
    vsync_p1_d = vsync_i;
    vsync_p2_d = vsync_p1_q;
    pixel_p2_d = fetch_p1_q ? mem_rdata : pixel_p2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      fetch_p1_q <= 1'b0;
      hsync_p1_q <= 1'b1;
      hsync_p2_q <= 1'b1;
      vsync_p1_q <= 1'b1;
      vsync_p2_q <= 1'b1;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      fetch_p1_q <= fetch_p1_d;
      hsync_p1_q <= hsync_p1_d;
      hsync_p2_q <= hsync_p2_d;
      vsync_p1_q <= vsync_p1_d;
      vsync_p2_q <= vsync_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    pixel_p2_q <= pixel_p2_d;
  end

  assign {r, g, b} = vld_p2_q ? pixel_p2_q : 3'b000;
  assign hsync     = hsync_p2_q;
  assign vsync     = vsync_p2_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: table vectors, scripted clear/reset sequences and
// randomized scans checked against a cycle-level framebuffer reference model.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam bit TB_VBLANK = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcnt, vcnt;
  logic        hsync_i, vsync_i, hsync, vsync, r, g, b;
  logic        wr_req, wr_ack, clr_start, clr_busy;
  logic [14:0] wr_addr, mem_addr;
  logic [2:0]  wr_data, clr_color, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.CLR_IN_VBLANK(TB_VBLANK)) dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port pixel RAM, one-cycle read latency
  logic [2:0] ram [0:FB_DEPTH-1] = '{default: 3'b000};
  always @(posedge clk) begin
    if (mem_en && mem_we && mem_addr < 15'(FB_DEPTH)) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we && mem_addr < 15'(FB_DEPTH)) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } pix_t;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        req;
    logic [14:0] addr;
    logic [2:0]  data;
    logic        en;
    logic        we;
    logic        ack;
    logic [14:0] maddr;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         chk_on  = 1'b0;
  logic [2:0] fb_ref [0:FB_DEPTH-1];
  pix_t       pipe_q[$];
  int         m_clr   = 0;  // 0 idle, 1 waiting for vblank, 2 sweeping
  int         m_caddr = 0;
  logic [2:0] m_ccol  = 3'b000;
  logic [2:0] m_latched = 3'b000;
  logic       last_ack = 1'b0;

  logic        s_en, s_we, s_ack, s_busy, s_hs, s_vs;
  logic [14:0] s_addr;
  logic [2:0]  s_wd, s_rgb;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (hcnt=%0d vcnt=%0d t=%0t)",
               name, act, exp, hcnt, vcnt, $time);
    end
  endtask

  // One clock cycle: inputs already driven; checks outputs, advances the model.
  task automatic step();
    logic        vis, fetch, e_en, e_we, e_ack;
    logic [14:0] e_addr;
    logic [2:0]  e_wd;
    pix_t        e_pix, np;
    int          st;
    vis   = (hcnt < 10'd640) && (vcnt < 10'd480);
    fetch = vis && (hcnt % 4 == 0);
    #2;
    e_en = 1'b0; e_we = 1'b0; e_ack = 1'b0; e_addr = '0; e_wd = '0;
    if (!rst) begin
      if (fetch) begin
        e_en   = 1'b1;
        e_addr = 15'((int'(vcnt) / 4) * FB_W + int'(hcnt) / 4);
      end else if (m_clr == 2) begin
        e_en = 1'b1; e_we = 1'b1; e_addr = 15'(m_caddr); e_wd = m_ccol;
      end else if (wr_req) begin
        e_ack = 1'b1;
        if (int'(wr_addr) < FB_DEPTH) begin
          e_en = 1'b1; e_we = 1'b1; e_addr = wr_addr; e_wd = wr_data;
        end
      end
    end
    s_en = mem_en; s_we = mem_we; s_ack = wr_ack; s_busy = clr_busy;
    s_addr = mem_addr; s_wd = mem_wdata; s_rgb = {r, g, b}; s_hs = hsync; s_vs = vsync;
    e_pix = '{3'b000, 1'b1, 1'b1};
    if (pipe_q.size() > 0) e_pix = pipe_q.pop_front();
    if (chk_on) begin
      check("mem_en", int'(s_en), int'(e_en));
      check("wr_ack", int'(s_ack), int'(e_ack));
      if (e_en) begin
        check("mem_we", int'(s_we), int'(e_we));
        check("mem_addr", int'(s_addr), int'(e_addr));
      end
      if (e_en && e_we) check("mem_wdata", int'(s_wd), int'(e_wd));
      check("clr_busy", int'(s_busy), int'(m_clr != 0));
      check("rgb", int'(s_rgb), int'(e_pix.rgb));
      check("hsync", int'(s_hs), int'(e_pix.hs));
      check("vsync", int'(s_vs), int'(e_pix.vs));
    end
    if (rst) begin
      m_clr = 0;
      pipe_q.delete();
      np = '{3'b000, 1'b1, 1'b1};
      pipe_q.push_back(np);
      pipe_q.push_back(np);
    end else begin
      st = m_clr;
      if (fetch) m_latched = fb_ref[(int'(vcnt) / 4) * FB_W + int'(hcnt) / 4];
      np.rgb = vis ? m_latched : 3'b000;
      np.hs  = hsync_i;
      np.vs  = vsync_i;
      pipe_q.push_back(np);
      if (e_en && e_we) fb_ref[e_addr] = e_wd;
      if (st == 2 && !fetch) begin
        if (m_caddr == FB_DEPTH - 1) m_clr = 0;
        else                         m_caddr++;
      end else if (st == 1 && vcnt == 10'd480 && hcnt == 10'd0) begin
        m_clr = 2;
      end else if (st == 0 && clr_start) begin
        m_ccol = clr_color; m_caddr = 0; m_clr = TB_VBLANK ? 1 : 2;
      end
    end
    last_ack = e_ack;
    @(posedge clk);
    #1;
  endtask

  task automatic sync_from_counts();
    hsync_i = !(hcnt >= 10'd656 && hcnt < 10'd752);
    vsync_i = !(vcnt >= 10'd490 && vcnt < 10'd492);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [12];
    int   bad, guard, clr_wr, acks_during;
    bit   jumped, ok;

    vecs = '{
      '{10'd4,   10'd0,   1'b1, 15'd500,   3'd3, 1'b1, 1'b0, 1'b0, 15'd1},
      '{10'd5,   10'd0,   1'b1, 15'd500,   3'd3, 1'b1, 1'b1, 1'b1, 15'd500},
      '{10'd4,   10'd4,   1'b0, 15'd0,     3'd0, 1'b1, 1'b0, 1'b0, 15'd161},
      '{10'd636, 10'd479, 1'b0, 15'd0,     3'd0, 1'b1, 1'b0, 1'b0, 15'd19199},
      '{10'd640, 10'd0,   1'b1, 15'd7,     3'd6, 1'b1, 1'b1, 1'b1, 15'd7},
      '{10'd641, 10'd1,   1'b1, 15'd161,   3'd5, 1'b1, 1'b1, 1'b1, 15'd161},
      '{10'd0,   10'd480, 1'b1, 15'd19199, 3'd1, 1'b1, 1'b1, 1'b1, 15'd19199},
      '{10'd0,   10'd480, 1'b1, 15'd19200, 3'd2, 1'b0, 1'b0, 1'b1, 15'd0},
      '{10'd9,   10'd8,   1'b0, 15'd0,     3'd0, 1'b0, 1'b0, 1'b0, 15'd0},
      '{10'd8,   10'd8,   1'b0, 15'd0,     3'd0, 1'b1, 1'b0, 1'b0, 15'd322},
      '{10'd2,   10'd500, 1'b1, 15'd32767, 3'd7, 1'b0, 1'b0, 1'b1, 15'd0},
      '{10'd3,   10'd3,   1'b1, 15'd40,    3'd4, 1'b1, 1'b1, 1'b1, 15'd40}
    };
    for (int i = 0; i < FB_DEPTH; i++) fb_ref[i] = 3'b000;

    rst = 1'b1; hcnt = 10'd5; vcnt = 10'd5; hsync_i = 1'b0; vsync_i = 1'b0;
    wr_req = 1'b1; wr_addr = 15'd10; wr_data = 3'd7; clr_start = 1'b0; clr_color = 3'd0;
    @(posedge clk);
    #1;
    chk_on = 1'b0;
    step();
    chk_on = 1'b1;
    step();
    check("reset_rgb", int'(s_rgb), 0);
    check("reset_hsync", int'(s_hs), 1);
    check("reset_vsync", int'(s_vs), 1);
    check("reset_busy", int'(s_busy), 0);
    check("reset_mem_en", int'(s_en), 0);
    check("reset_wr_ack", int'(s_ack), 0);
    rst = 1'b0; wr_req = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;

    // Arbitration vectors (clear engine idle)
    for (int i = 0; i < 12; i++) begin
      hcnt = vecs[i].h; vcnt = vecs[i].v;
      wr_req = vecs[i].req; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      step();
      check($sformatf("vec%0d_en", i), int'(s_en), int'(vecs[i].en));
      check($sformatf("vec%0d_ack", i), int'(s_ack), int'(vecs[i].ack));
      if (vecs[i].en) begin
        check($sformatf("vec%0d_we", i), int'(s_we), int'(vecs[i].we));
        check($sformatf("vec%0d_addr", i), int'(s_addr), int'(vecs[i].maddr));
      end
    end
    wr_req = 1'b0;

    // Cell 161 holds 101: scan lines 4..7
    for (int v = 4; v < 8; v++) begin
      for (int h = 0; h < 16; h++) begin
        hcnt = 10'(h); vcnt = 10'(v);
        step();
        if (h >= 6 && h <= 9) check("cell161_rgb", int'(s_rgb), 5);
        if (v == 4 && h == 4) check("cell161_read_addr", int'(s_addr), 161);
      end
    end

    // Randomized scan segments with a concurrent writer
    for (int seg = 0; seg < 120; seg++) begin
      int v0, x0;
      v0 = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 479)) : int'($urandom_range(480, 524));
      x0 = int'($urandom_range(0, 199));
      for (int k = 0; k < 24 && 4 * x0 + k < 800; k++) begin
        hcnt = 10'(4 * x0 + k); vcnt = 10'(v0);
        hsync_i = 1'($urandom); vsync_i = 1'($urandom);
        if (last_ack || !wr_req) begin
          wr_req  = ($urandom_range(0, 2) == 0);
          wr_addr = ($urandom_range(0, 4) == 0) ? 15'($urandom_range(19200, 32767))
                  : 15'(((v0 % 480) / 4) * FB_W + (x0 + int'($urandom_range(0, 7))) % FB_W);
          wr_data = 3'($urandom);
        end
        step();
      end
    end
    wr_req = 1'b0;

    // Clear to green: armed at line 100, sweeps from vertical blank
    hcnt = 10'd1; vcnt = 10'd100; sync_from_counts();
    clr_start = 1'b1; clr_color = 3'b010;
    step();
    clr_start = 1'b0; clr_color = 3'b111;
    for (int h = 2; h < 31; h++) begin
      hcnt = 10'(h);
      step();
    end
    check("clr_busy_armed", int'(s_busy), 1);
    vcnt = 10'd479;
    for (int h = 636; h < 640; h++) begin
      hcnt = 10'(h);
      step();
      check("armed_no_write", int'(s_en && s_we), 0);
    end
    hcnt = 10'd0; vcnt = 10'd480; sync_from_counts();
    step();
    wr_req = 1'b1; wr_addr = 15'd77; wr_data = 3'b100;
    clr_wr = 0; acks_during = 0; guard = 0; jumped = 1'b0;
    while (m_clr != 0 && guard < 25000) begin
      hcnt = hcnt + 10'd1;
      if (hcnt == 10'd800) begin
        hcnt = 10'd0;
        vcnt = (vcnt == 10'd524) ? 10'd0 : vcnt + 10'd1;
      end
      if (!jumped && m_caddr >= 19000) begin
        jumped = 1'b1; hcnt = 10'd0; vcnt = 10'd0;
      end
      sync_from_counts();
      step();
      if (s_en && s_we && s_wd == 3'b010) clr_wr++;
      if (s_ack) acks_during++;
      guard++;
    end
    check("clear_timeout", int'(guard < 25000), 1);
    check("clear_write_count", clr_wr, FB_DEPTH);
    check("writer_acks_during_clear", acks_during, 0);
    hcnt = hcnt + 10'd1; sync_from_counts();
    step();
    check("clr_busy_after_sweep", int'(s_busy), 0);
    ok = s_ack;
    if (!ok) begin
      hcnt = hcnt + 10'd1; sync_from_counts();
      step();
      ok = s_ack;
    end
    check("writer_ack_after_clear", int'(ok), 1);
    wr_req = 1'b0;
    hcnt = hcnt + 10'd1; sync_from_counts();
    step();
    bad = 0;
    for (int i = 0; i < FB_DEPTH; i++)
      if (ram[i] !== ((i == 77) ? 3'b100 : 3'b010)) bad++;
    check("ram_cells_wrong_after_clear", bad, 0);

    // Display after the clear
    for (int vi = 0; vi < 12; vi++) begin
      vcnt = (vi < 8) ? 10'(vi) : 10'(468 + vi);
      for (int h = 0; h < 640; h++) begin
        hcnt = 10'(h); sync_from_counts();
        step();
        if (vi == 2 && h == 10) check("green_pixel", int'(s_rgb), 3'b010);
        if (vi == 0 && h == 310) check("cell77_pixel", int'(s_rgb), 3'b100);
      end
    end

    // Second clear, ignored restart, then reset mid-sweep
    hcnt = 10'd700; vcnt = 10'd479; sync_from_counts();
    clr_start = 1'b1; clr_color = 3'b110;
    step();
    clr_start = 1'b0;
    hcnt = 10'd0; vcnt = 10'd480; sync_from_counts();
    step();
    for (int k = 1; k <= 100; k++) begin
      hcnt = 10'(k); sync_from_counts();
      clr_start = (k == 50); clr_color = (k == 50) ? 3'b001 : 3'b000;
      step();
      if (k == 60) begin
        check("restart_ignored_wdata", int'(s_wd), 3'b110);
        check("restart_ignored_busy", int'(s_busy), 1);
      end
    end
    clr_start = 1'b0;
    wr_req = 1'b1; wr_addr = 15'd300; wr_data = 3'b101;
    rst = 1'b1; hcnt = 10'd101;
    step();
    check("rst_mem_en", int'(s_en), 0);
    check("rst_wr_ack", int'(s_ack), 0);
    rst = 1'b0; hcnt = 10'd102;
    step();
    check("post_rst_busy", int'(s_busy), 0);
    check("post_rst_wr_ack", int'(s_ack), 1);
    check("post_rst_addr", int'(s_addr), 300);
    wr_req = 1'b0; hcnt = 10'd103;
    step();
    check("ram300", int'(ram[300]), 3'b101);
    check("ram50_partial", int'(ram[50]), 3'b110);
    check("ram5000_untouched", int'(ram[5000]), 3'b010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
